// File: rtl/demux_1_4_buf_pkg.sv
// Shared constants for the registered 1-to-4 demultiplexer: channel count,
// select width, channel indices and the select-to-one-hot decode.
package demux_1_4_buf_pkg;

   localparam int unsigned NCH   = 4;
   localparam int unsigned SEL_W = 2;

   localparam logic [SEL_W-1:0] CH0 = 2'd0;
   localparam logic [SEL_W-1:0] CH1 = 2'd1;
   localparam logic [SEL_W-1:0] CH2 = 2'd2;
   localparam logic [SEL_W-1:0] CH3 = 2'd3;

   function automatic logic [NCH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
      logic [NCH-1:0] oh;
      oh = '0;
      case (sel)
         CH0:     oh = 4'b0001;
         CH1:     oh = 4'b0010;
         CH2:     oh = 4'b0100;
         CH3:     oh = 4'b1000;
         default: oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/demux_1_4_buf_slot.sv
// Single-entry output slot: data register, valid flag and a wrapping count of
// beats delivered to the consumer.
module demux_slot #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ready,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] data_q,  data_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             del;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      count_d = count_q;
      del     = valid_q & ready;
      if (del) begin
         valid_d = 1'b0;
         count_d = count_q + 1'b1;
      end
      // A load overrides the drain so the slot refills without a bubble.
      if (load) begin
         data_d  = load_data;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   assign data  = data_q;
   assign valid = valid_q;
   assign count = count_q;

endmodule

// File: rtl/demux_1_4_buf.sv
// Registered 1-to-4 demultiplexer with valid/ready on the input and each output;
// readiness depends only on the addressed slot so one stalled consumer never blocks others.
module demux_1_4_buf
   import demux_1_4_buf_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [1:0]           in_sel,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [4*WIDTH-1:0]   y_data,
   output logic [3:0]           y_valid,
   input  logic [3:0]           y_ready,
   output logic [4*CNT_W-1:0]   xfer_cnt
);

   logic           acc;
   logic [NCH-1:0] load;

   always_comb begin
      in_ready = ~y_valid[in_sel] | y_ready[in_sel];
      acc      = in_valid & in_ready;
      load     = acc ? sel_onehot(in_sel) : '0;
   end

   for (genvar k = 0; k < NCH; k++) begin : g_slot
      demux_slot #(
         .WIDTH (WIDTH),
         .CNT_W (CNT_W)
      ) u_slot (
         .clk       (clk),
         .rst       (rst),
         .load      (load[k]),
         .load_data (in_data),
         .ready     (y_ready[k]),
         .data      (y_data[k*WIDTH +: WIDTH]),
         .valid     (y_valid[k]),
         .count     (xfer_cnt[k*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_demux_1_4_buf.sv
// Directed and random checks of demux_1_4_buf: reset, routing, backpressure
// isolation, drain-and-refill, counter wrap and a scoreboarded soak.
module tb_demux_1_4_buf;

   localparam int WIDTH = 4;
   localparam int CNT_W = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic [WIDTH-1:0]   in_data;
   logic [1:0]         in_sel;
   logic               in_valid;
   logic               in_ready;
   logic [4*WIDTH-1:0] y_data;
   logic [3:0]         y_valid;
   logic [3:0]         y_ready;
   logic [4*CNT_W-1:0] xfer_cnt;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   logic [WIDTH-1:0] sbq [4][$];
   int               cnt_m [4];

   demux_1_4_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .y_data   (y_data),
      .y_valid  (y_valid),
      .y_ready  (y_ready),
      .xfer_cnt (xfer_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (in_valid === 1'b1)
         assert (!$isunknown(in_sel)) else $error("FAIL xsel: in_sel=%b while in_valid=1", in_sel);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
      #1;
   endtask

   function automatic logic [WIDTH-1:0] ych(input int k);
      return y_data[k*WIDTH +: WIDTH];
   endfunction

   function automatic logic [CNT_W-1:0] ycnt(input int k);
      return xfer_cnt[k*CNT_W +: CNT_W];
   endfunction

   initial begin
      logic [3:0]       exp_v;
      logic [3:0]       del;
      logic             exp_rdy;
      logic             acc;
      logic [1:0]       a_sel;
      logic [WIDTH-1:0] a_data;

      rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; y_ready = '0;
      #12;
      check("reset_valid", 64'(y_valid), 64'(4'b0000));
      check("reset_data",  64'(y_data),  64'(0));
      check("reset_cnt",   64'(xfer_cnt), 64'(0));
      rst = 1'b0;
      tick();

      // Basic routing
      y_ready = 4'b1111;
      drive(1'b1, 2'd0, 4'hA);
      check("route_rdy0", 64'(in_ready), 64'(1));
      tick();
      check("route_v0", 64'(y_valid), 64'(4'b0001));
      check("route_d0", 64'(ych(0)), 64'(4'hA));
      drive(1'b1, 2'd1, 4'h5);
      tick();
      check("route_v1", 64'(y_valid), 64'(4'b0010));
      check("route_d1", 64'(ych(1)), 64'(4'h5));
      drive(1'b1, 2'd2, 4'hC);
      tick();
      check("route_v2", 64'(y_valid), 64'(4'b0100));
      check("route_d2", 64'(ych(2)), 64'(4'hC));
      drive(1'b1, 2'd3, 4'h3);
      tick();
      check("route_v3", 64'(y_valid), 64'(4'b1000));
      check("route_d3", 64'(ych(3)), 64'(4'h3));
      drive(1'b0, 2'd0, 4'h0);
      tick();
      check("route_empty", 64'(y_valid), 64'(4'b0000));
      check("route_cnt", 64'(xfer_cnt), 64'(32'h01010101));

      // Backpressure isolation
      y_ready = 4'b1110;
      drive(1'b1, 2'd0, 4'h6);
      tick();
      check("bp_fill", 64'(y_valid), 64'(4'b0001));
      drive(1'b1, 2'd0, 4'h7);
      check("bp_blocked", 64'(in_ready), 64'(0));
      tick();
      check("bp_hold_d", 64'(ych(0)), 64'(4'h6));
      check("bp_hold_v", 64'(y_valid), 64'(4'b0001));
      drive(1'b1, 2'd2, 4'h9);
      check("bp_other_rdy", 64'(in_ready), 64'(1));
      tick();
      check("bp_other_v", 64'(y_valid), 64'(4'b0101));
      check("bp_other_d", 64'(ych(2)), 64'(4'h9));
      drive(1'b0, 2'd0, 4'h0);
      tick();
      check("bp_cnt", 64'(xfer_cnt), 64'(32'h01020101));

      // Simultaneous drain and refill on channel 1
      y_ready = 4'b0000;
      drive(1'b1, 2'd1, 4'h4);
      tick();
      check("dr_fill", 64'(y_valid), 64'(4'b0011));
      y_ready = 4'b0010;
      drive(1'b1, 2'd1, 4'hB);
      check("dr_rdy", 64'(in_ready), 64'(1));
      tick();
      check("dr_data", 64'(ych(1)), 64'(4'hB));
      check("dr_valid", 64'(y_valid), 64'(4'b0011));
      check("dr_cnt1", 64'(ycnt(1)), 64'(2));
      y_ready = 4'b1111;
      drive(1'b0, 2'd0, 4'h0);
      tick();
      check("dr_drain", 64'(y_valid), 64'(4'b0000));
      check("dr_cnt", 64'(xfer_cnt), 64'(32'h01020302));

      // Reset asserted mid-cycle with all slots full
      y_ready = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 2'(k), 4'(k + 1));
         tick();
      end
      drive(1'b0, 2'd0, 4'h0);
      check("full_v", 64'(y_valid), 64'(4'b1111));
      check("full_d", 64'(y_data), 64'(16'h4321));
      rst = 1'b1;
      #1;
      check("async_rst_v", 64'(y_valid), 64'(0));
      check("async_rst_d", 64'(y_data), 64'(0));
      check("async_rst_c", 64'(xfer_cnt), 64'(0));
      drive(1'b1, 2'd2, 4'hE);
      tick();
      check("rst_no_accept", 64'(y_valid), 64'(0));
      rst = 1'b0;
      #1;
      tick();
      check("post_rst_v", 64'(y_valid), 64'(4'b0100));
      check("post_rst_d", 64'(ych(2)), 64'(4'hE));
      y_ready = 4'b1111;
      drive(1'b0, 2'd0, 4'h0);
      tick();

      // Counter wrap on channel 3
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, 2'd3, 4'(i));
         tick();
      end
      drive(1'b0, 2'd0, 4'h0);
      check("wrap_255", 64'(ycnt(3)), 64'(255));
      tick();
      check("wrap_zero", 64'(xfer_cnt), 64'(32'h00010000));

      // Random soak against per-channel scoreboard
      rst = 1'b1;
      #1;
      rst = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) cnt_m[k] = 0;
      for (int c = 0; c < 10000; c++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_sel   = 2'($urandom_range(0, 3));
         in_data  = 4'($urandom);
         y_ready  = 4'($urandom);
         #1;
         for (int k = 0; k < 4; k++) exp_v[k] = (sbq[k].size() != 0);
         check("soak_valid", 64'(y_valid), 64'(exp_v));
         exp_rdy = ~exp_v[in_sel] | y_ready[in_sel];
         if (in_valid) check("soak_in_ready", 64'(in_ready), 64'(exp_rdy));
         del = exp_v & y_ready;
         for (int k = 0; k < 4; k++)
            if (del[k]) check("soak_data", 64'(ych(k)), 64'(sbq[k][0]));
         acc    = in_valid & exp_rdy;
         a_sel  = in_sel;
         a_data = in_data;
         tick();
         for (int k = 0; k < 4; k++)
            if (del[k]) begin
               void'(sbq[k].pop_front());
               cnt_m[k] = (cnt_m[k] + 1) % 256;
            end
         if (acc) sbq[a_sel].push_back(a_data);
      end
      for (int k = 0; k < 4; k++) check("soak_cnt", 64'(ycnt(k)), 64'(cnt_m[k]));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
